// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU decode/issue stage with registered command output
// Decodes OP/OP-IMM/LUI/AUIPC into ALU controls; unsupported encodings still issue, flagged illegal.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_sub,
  output logic [4:0]      rd_addr,
  output logic            rd_write,
  output logic            illegal,
  output logic [31:0]     issue_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [2:0]      dec_op;
  logic            dec_sub;
  logic            dec_illegal;
  logic            dec_rd_write;
  logic            accept;
  logic            consume;
  logic            f3_addsub_or_sr;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign dec_rd   = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign f3_addsub_or_sr = (funct3 == 3'b000) || (funct3 == 3'b101);

  always_comb begin
    dec_a       = '0;
    dec_b       = '0;
    dec_op      = 3'b000;
    dec_sub     = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a       = rs1_data;
        dec_b       = rs2_data;
        dec_op      = funct3;
        dec_sub     = f3_addsub_or_sr && instr[30];
        dec_illegal = !((funct7 == F7_ZERO) || ((funct7 == F7_ALT) && f3_addsub_or_sr));
      end
      OPC_OP_IMM: begin
        dec_a  = rs1_data;
        dec_op = funct3;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift immediates carry only a 5-bit shamt; upper bits are funct7.
          dec_b = {{(XLEN-5){1'b0}}, instr[24:20]};
        end else begin
          dec_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
        dec_sub = (funct3 == 3'b101) && instr[30];
        if (funct3 == 3'b001) begin
          dec_illegal = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          dec_illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
        end
      end
      OPC_LUI: begin
        dec_b = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = {instr[31:12], 12'b0};
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_rd_write = !dec_illegal && (dec_rd != 5'd0);

  assign instr_ready = !flush && (!out_valid || out_ready);
  assign accept      = instr_valid && instr_ready;
  assign consume     = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 3'b000;
      alu_sub     <= 1'b0;
      rd_addr     <= 5'd0;
      rd_write    <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= 32'd0;
    end else begin
      // A consume still counts even when flush discards the register this cycle.
      if (consume) begin
        issue_count <= issue_count + 32'd1;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        alu_a     <= dec_a;
        alu_b     <= dec_b;
        alu_op    <= dec_op;
        alu_sub   <= dec_sub;
        rd_addr   <= dec_rd;
        rd_write  <= dec_rd_write;
        illegal   <= dec_illegal;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_sub;
  logic [4:0]  rd_addr;
  logic        rd_write;
  logic        illegal;
  logic [31:0] issue_count;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sub(alu_sub),
    .rd_addr(rd_addr), .rd_write(rd_write), .illegal(illegal),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic sub, input logic [4:0] rd,
                         input logic wr, input logic ill, input logic [31:0] cnt);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".a"}, alu_a, a);
    chk({tag, ".b"}, alu_b, b);
    chk({tag, ".op"}, {29'd0, alu_op}, {29'd0, op});
    chk({tag, ".sub"}, {31'd0, alu_sub}, {31'd0, sub});
    chk({tag, ".rd"}, {27'd0, rd_addr}, {27'd0, rd});
    chk({tag, ".wr"}, {31'd0, rd_write}, {31'd0, wr});
    chk({tag, ".ill"}, {31'd0, illegal}, {31'd0, ill});
    chk({tag, ".cnt"}, issue_count, cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".a"}, alu_a, 32'd0);
    chk({tag, ".b"}, alu_b, 32'd0);
    chk({tag, ".op"}, {29'd0, alu_op}, 32'd0);
    chk({tag, ".sub"}, {31'd0, alu_sub}, 32'd0);
    chk({tag, ".rd"}, {27'd0, rd_addr}, 32'd0);
    chk({tag, ".wr"}, {31'd0, rd_write}, 32'd0);
    chk({tag, ".ill"}, {31'd0, illegal}, 32'd0);
    chk({tag, ".cnt"}, issue_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; pc = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk_zero("reset");
    #9 reset = 1'b0;
    step();
    chk("idle.valid", {31'd0, out_valid}, 32'd0);

    // Scenario 1: add then sub
    instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7; instr_valid = 1'b1;
    #1;
    chk("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
    chk("add.ready", {31'd0, instr_ready}, 32'd1);
    step();
    chk_cmd("add", 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 32'd0);
    instr = 32'h402081B3; out_ready = 1'b1;
    #1 chk("sub.ready", {31'd0, instr_ready}, 32'd1);
    step();
    chk_cmd("sub", 32'd5, 32'd7, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd1);

    // Scenario 2: immediates
    instr = 32'h40435293; rs1_data = 32'hF0000000; rs2_data = 32'h12345678;
    step();
    chk_cmd("srai", 32'hF0000000, 32'd4, 3'b101, 1'b1, 5'd5, 1'b1, 1'b0, 32'd2);
    instr = 32'hFFF00093; rs1_data = 32'd0;
    step();
    chk_cmd("addi", 32'd0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 1'b1, 1'b0, 32'd3);
    instr = 32'h12345137; rs1_data = 32'hDEADBEEF;
    step();
    chk_cmd("lui", 32'd0, 32'h12345000, 3'b000, 1'b0, 5'd2, 1'b1, 1'b0, 32'd4);

    // Scenario 3: back-to-back auipc, and, slli
    instr = 32'h00001297; pc = 32'h00001000;
    step();
    chk_cmd("auipc", 32'h00001000, 32'h00001000, 3'b000, 1'b0, 5'd5, 1'b1, 1'b0, 32'd5);
    instr = 32'h0020F3B3; rs1_data = 32'hFF00FF00; rs2_data = 32'h0F0F0F0F;
    step();
    chk_cmd("and", 32'hFF00FF00, 32'h0F0F0F0F, 3'b111, 1'b0, 5'd7, 1'b1, 1'b0, 32'd6);
    instr = 32'h01F21213; rs1_data = 32'h00000003;
    step();
    chk_cmd("slli", 32'h00000003, 32'd31, 3'b001, 1'b0, 5'd4, 1'b1, 1'b0, 32'd7);
    // stall with a new instruction waiting
    out_ready = 1'b0; instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
    #1 chk("stall.ready", {31'd0, instr_ready}, 32'd0);
    step();
    chk_cmd("stall1", 32'h00000003, 32'd31, 3'b001, 1'b0, 5'd4, 1'b1, 1'b0, 32'd7);
    step();
    chk_cmd("stall2", 32'h00000003, 32'd31, 3'b001, 1'b0, 5'd4, 1'b1, 1'b0, 32'd7);
    out_ready = 1'b1;
    #1 chk("release.ready", {31'd0, instr_ready}, 32'd1);
    step();
    chk_cmd("release", 32'd9, 32'd4, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0, 32'd8);

    // Scenario 4: illegal encodings and rd=x0
    instr = 32'h0000000B;
    step();
    chk_cmd("custom0", 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 32'd9);
    instr = 32'h40121213; rs1_data = 32'd1;
    step();
    chk("slli_bad.ill", {31'd0, illegal}, 32'd1);
    chk("slli_bad.wr", {31'd0, rd_write}, 32'd0);
    chk("slli_bad.cnt", issue_count, 32'd10);
    instr = 32'h00208033; rs1_data = 32'd2; rs2_data = 32'd3;
    step();
    chk_cmd("add_x0", 32'd2, 32'd3, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 32'd11);
    instr = 32'h402091B3;
    step();
    chk("sll_bad.ill", {31'd0, illegal}, 32'd1);
    chk("sll_bad.wr", {31'd0, rd_write}, 32'd0);
    chk("sll_bad.cnt", issue_count, 32'd12);

    // Scenario 5: flush while held, then flush with a consume
    out_ready = 1'b0; flush = 1'b1; instr = 32'h002081B3;
    #1 chk("flush.ready", {31'd0, instr_ready}, 32'd0);
    step();
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.cnt", issue_count, 32'd12);
    flush = 1'b0; instr_valid = 1'b0;
    step();
    chk("postflush.valid", {31'd0, out_valid}, 32'd0);
    instr_valid = 1'b1; instr = 32'hFFF00093; rs1_data = 32'd0; out_ready = 1'b1;
    step();
    chk("load.valid", {31'd0, out_valid}, 32'd1);
    chk("load.cnt", issue_count, 32'd12);
    flush = 1'b1;
    step();
    chk("flushcons.valid", {31'd0, out_valid}, 32'd0);
    chk("flushcons.cnt", issue_count, 32'd13);

    // Scenario 6: asynchronous reset while holding a command
    flush = 1'b0; out_ready = 1'b0;
    instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    step();
    chk("prereset.valid", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    #1 reset = 1'b0;
    step();
    chk_cmd("after_reset", 32'd5, 32'd7, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the integer ALU's control and operand interface: `a`, `b`, `op[2:0]`, and `subtract_or_arithmetic_shift`.
- Accepts one RV32I instruction per cycle through a valid/ready handshake.
- Emits combinational register-file read addresses and captures the returned operands.
- Registers a fully decoded ALU command, with destination info, for the execute stage, under an output valid/ready handshake with flush.

Parameters:
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
instr_valid  input  1  upstream instruction valid
instr_ready  output  1  stage can accept instruction this cycle
instr  input  32  instruction word
pc  input  XLEN  instruction address
rs1_addr  output  5  instr[19:15], combinational
rs2_addr  output  5  instr[24:20], combinational
rs1_data  input  XLEN  register-file read data for rs1_addr, same cycle
rs2_data  input  XLEN  register-file read data for rs2_addr, same cycle
flush  input  1  discard held command, block accept this cycle
out_valid  output  1  registered command valid
out_ready  input  1  execute stage consumes command
alu_a  output  XLEN  ALU operand a
alu_b  output  XLEN  ALU operand b
alu_op  output  3  ALU op (funct3 encoding)
alu_sub  output  1  subtract / arithmetic-shift select
rd_addr  output  5  destination register
rd_write  output  1  writeback enable
illegal  output  1  instruction not supported by this stage
issue_count  output  32  count of commands consumed downstream

Behaviour:
Clock and reset:
- One clock domain, `clk`.
- `reset` is asynchronous, active-high.
- On reset: `out_valid`, `alu_a`, `alu_b`, `alu_op`, `alu_sub`, `rd_addr`, `rd_write`, `illegal` and `issue_count` all clear to 0.
- Reset asserted mid-transfer drops the held command with no downstream side effect.

Handshake:
- `instr_ready = !flush && (!out_valid || out_ready)`.
- Accept occurs when `instr_valid && instr_ready`. The output register loads at the next edge and `out_valid` is 1 after that edge (latency 1 cycle).
- Consume occurs when `out_valid && out_ready`. `issue_count` increments at that edge and wraps 0xFFFFFFFF -> 0.
- Consume and accept in the same cycle: the register loads the new command, `out_valid` stays 1, and full throughput (1 per cycle) is maintained.
- Consume without accept: `out_valid` goes to 0.
- While `out_valid && !out_ready`, all output fields hold stable.
- `flush` has the highest priority: `out_valid` goes to 0 at the next edge and no accept occurs. A command consumed in the same cycle as `flush` still counts.

Decode (on accept):
OP (0110011):
- `a` = `rs1_data`, `b` = `rs2_data`, `op` = funct3.
- `sub` = instr[30] when funct3 is 000 or 101.
- Legal funct7 values are 0000000 for all funct3, and 0100000 only for funct3 000 or 101. Anything else is illegal.

OP-IMM (0010011):
- `a` = `rs1_data`, `op` = funct3.
- `b` = sign-extended instr[31:20].
- Shifts (funct3 001/101): `b` = zero-extended shamt instr[24:20].
- `sub` = 1 only for funct3 101 with instr[30] = 1 (srai).
- slli requires funct7 = 0. srli/srai require funct7 of 0000000 or 0100000. Anything else is illegal.
- addi never subtracts.

LUI (0110111): `a` = 0, `b` = {instr[31:12], 12'b0}, `op` = 000, `sub` = 0.

AUIPC (0010111): `a` = `pc`, `b` = {instr[31:12], 12'b0}, `op` = 000, `sub` = 0.

Register addressing and write enable:
- `rd_addr` = instr[11:7].
- `rd_write` = 1 when the instruction is legal and `rd_addr != 0`.

Any other opcode:
- `illegal` = 1, `rd_write` = 0.
- `a`, `b`, `op` and `sub` are all 0.
- The command still issues normally so downstream trap logic sees it.

Test Plan:
1. Accept `add` x3,x1,x2 (0x002081B3) with `rs1_data`=5, `rs2_data`=7 -> next cycle `out_valid`=1, `alu_a`=5, `alu_b`=7, `alu_op`=000, `alu_sub`=0, `rd_addr`=3, `rd_write`=1. Then `sub` (0x402081B3) -> `alu_sub`=1.
2. Immediate decode:
   - `srai` x5,x6,4 (0x40435293), `rs1_data`=0xF0000000 -> `alu_b`=4, `alu_op`=101, `alu_sub`=1.
   - `addi` x1,x0,-1 (0xFFF00093) -> `alu_b`=0xFFFFFFFF, `alu_sub`=0.
   - `lui` x2 (0x12345137) -> `alu_a`=0, `alu_b`=0x12345000.
3. Back-to-back issue of 3 instructions with `out_ready`=1 -> 3 consecutive `out_valid` cycles, `issue_count`=3. Then hold `out_ready`=0 for 2 cycles with `instr_valid`=1 -> `instr_ready`=0 and outputs stable. On release, one consume plus accept occurs in the same cycle.
4. Illegal encodings:
   - 0x0000000B -> `illegal`=1, `rd_write`=0, issued and counted.
   - `slli` with funct7=0100000 -> `illegal`=1.
   - `add` x0 -> `rd_write`=0, `illegal`=0.
5. Command held with `out_ready`=0, then assert `flush` with `instr_valid`=1 -> `instr_ready`=0, next cycle `out_valid`=0, `issue_count` unchanged.
6. Assert `reset` asynchronously mid-cycle while `out_valid`=1 -> `out_valid` and all fields read 0 immediately. After release, `issue_count`=0 and the first accept behaves as in scenario 1.
